// File: rtl/mem_port_arbiter.sv
// Shares the single processor-to-memory port between the I-cache fetch side
// and the D-cache load/store side. It locks the grant across rejections,
// tracks owners of accepted load tags and steers returning data to the owner.
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ic_cmd,
    input  logic [XLEN-1:0]  ic_addr,
    output logic             ic_gnt,
    output logic [TAG_W-1:0] ic_acc_tag,
    output logic             ic_rsp_valid,
    input  logic [1:0]       dc_cmd,
    input  logic [XLEN-1:0]  dc_addr,
    input  logic [63:0]      dc_wdata,
    output logic             dc_gnt,
    output logic [TAG_W-1:0] dc_acc_tag,
    output logic             dc_rsp_valid,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic             spurious_tag
);

    localparam int unsigned NTAGS = 1 << TAG_W;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic             r_lock;
    logic             r_lock_owner;
    logic [CNT_W-1:0] r_starve;
    logic [NTAGS-1:0] r_tbl_vld;
    logic [NTAGS-1:0] r_tbl_own;
    logic             r_spurious;

    logic w_ic_req;
    logic w_dc_req;
    logic w_starved;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_accept;
    logic w_ret_hit;

    // An I-side STORE is illegal and counts as no request
    assign w_ic_req  = (ic_cmd == CMD_LOAD);
    assign w_dc_req  = (dc_cmd == CMD_LOAD) || (dc_cmd == CMD_STORE);
    assign w_starved = (r_starve == CNT_W'(STARVE_MAX));

    // Grant selection: live lock first, then starvation override, then D over I
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (reset) begin
            if (r_lock && (r_lock_owner == OWN_I) && w_ic_req) begin
                w_gnt_i = 1'b1;
            end else if (r_lock && (r_lock_owner == OWN_D) && w_dc_req) begin
                w_gnt_d = 1'b1;
            end else if (w_starved && w_ic_req) begin
                w_gnt_i = 1'b1;
            end else if (w_dc_req) begin
                w_gnt_d = 1'b1;
            end else if (w_ic_req) begin
                w_gnt_i = 1'b1;
            end
        end
    end

    // Zero-latency mux of the granted side onto the memory port
    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_gnt_d) begin
            proc2mem_command = dc_cmd;
            proc2mem_addr    = dc_addr;
            proc2mem_data    = dc_wdata;
        end else if (w_gnt_i) begin
            proc2mem_command = CMD_LOAD;
            proc2mem_addr    = ic_addr;
        end
    end

    assign w_accept   = (w_gnt_i || w_gnt_d) && (mem2proc_response != '0);
    assign ic_gnt     = w_gnt_i;
    assign dc_gnt     = w_gnt_d;
    assign ic_acc_tag = (w_gnt_i && w_accept) ? mem2proc_response : '0;
    assign dc_acc_tag = (w_gnt_d && w_accept) ? mem2proc_response : '0;

    // Return steering from the owner table
    assign w_ret_hit    = reset && (mem2proc_tag != '0) && r_tbl_vld[mem2proc_tag];
    assign ic_rsp_valid = w_ret_hit && (r_tbl_own[mem2proc_tag] == OWN_I);
    assign dc_rsp_valid = w_ret_hit && (r_tbl_own[mem2proc_tag] == OWN_D);
    assign rsp_data     = mem2proc_data;
    assign rsp_tag      = mem2proc_tag;
    assign spurious_tag = r_spurious && reset;

    // Lock, starvation counter, owner table and sticky spurious flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_I;
            r_starve     <= '0;
            r_tbl_vld    <= '0;
            r_tbl_own    <= '0;
            r_spurious   <= 1'b0;
        end else begin
            r_lock <= (w_gnt_i || w_gnt_d) && (mem2proc_response == '0);
            if (w_gnt_d) begin
                r_lock_owner <= OWN_D;
            end else if (w_gnt_i) begin
                r_lock_owner <= OWN_I;
            end

            if (w_gnt_i && w_accept) begin
                r_starve <= '0;
            end else if (w_ic_req && !w_gnt_i && !w_starved) begin
                r_starve <= r_starve + CNT_W'(1);
            end

            // Return clears first so a same-tag acceptance below overrides it
            if (mem2proc_tag != '0) begin
                if (r_tbl_vld[mem2proc_tag]) begin
                    r_tbl_vld[mem2proc_tag] <= 1'b0;
                end else begin
                    r_spurious <= 1'b1;
                end
            end
            if (w_accept && (proc2mem_command == CMD_LOAD)) begin
                r_tbl_vld[mem2proc_response] <= 1'b1;
                r_tbl_own[mem2proc_response] <= w_gnt_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks with a tag-owner
// scoreboard filled on load acceptance and drained on data return.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  ic_cmd;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic [3:0]  ic_acc_tag;
    logic        ic_rsp_valid;
    logic [1:0]  dc_cmd;
    logic [31:0] dc_addr;
    logic [63:0] dc_wdata;
    logic        dc_gnt;
    logic [3:0]  dc_acc_tag;
    logic        dc_rsp_valid;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        spurious_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] tag;
        bit         own_d;
    } ret_t;
    ret_t sb[$];

    mem_port_arbiter #(.XLEN(32), .TAG_W(4), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .ic_cmd(ic_cmd), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_acc_tag(ic_acc_tag), .ic_rsp_valid(ic_rsp_valid),
        .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_acc_tag(dc_acc_tag), .dc_rsp_valid(dc_rsp_valid),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .spurious_tag(spurious_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply one cycle of inputs, then let combinational outputs settle
    task automatic drive(input logic [1:0] icc, input logic [31:0] ica,
                         input logic [1:0] dcc, input logic [31:0] dca,
                         input logic [63:0] wd, input logic [3:0] resp,
                         input logic [3:0] rtag);
        ic_cmd            = icc;
        ic_addr           = ica;
        dc_cmd            = dcc;
        dc_addr           = dca;
        dc_wdata          = wd;
        mem2proc_response = resp;
        mem2proc_tag      = rtag;
        mem2proc_data     = {16'hCAFE, 44'h0, rtag};
        #2;
    endtask

    task automatic sb_pop(input logic [3:0] tag, output bit found, output bit own_d);
        found = 1'b0;
        own_d = 1'b0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].tag == tag) begin
                found = 1'b1;
                own_d = sb[i].own_d;
                sb.delete(i);
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 4'd0);
        tick();
        reset = 1'b1;
        sb.delete();
    endtask

    // Return tag t and compare the steering against the scoreboard
    task automatic test_return(input string name, input logic [3:0] t);
        bit found, own_d;
        sb_pop(t, found, own_d);
        drive(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, t);
        checks++;
        if (dc_rsp_valid !== (found && own_d)) begin
            failures++;
            $display("FAIL %s_dc_rsp_valid got=%0b exp=%0b", name, dc_rsp_valid, found && own_d);
        end
        checks++;
        if (ic_rsp_valid !== (found && !own_d)) begin
            failures++;
            $display("FAIL %s_ic_rsp_valid got=%0b exp=%0b", name, ic_rsp_valid, found && !own_d);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(2'd1, 32'h100, 2'd1, 32'h200, 64'h1, 4'd3, 4'd5);
        checks++;
        if ({ic_gnt, dc_gnt, proc2mem_command} !== 4'b0) begin
            failures++;
            $display("FAIL reset_gnt_cmd got=%b exp=0000", {ic_gnt, dc_gnt, proc2mem_command});
        end
        checks++;
        if ({ic_acc_tag, dc_acc_tag, ic_rsp_valid, dc_rsp_valid, spurious_tag} !== 11'b0) begin
            failures++;
            $display("FAIL reset_tags got=%b exp=0", {ic_acc_tag, dc_acc_tag, ic_rsp_valid, dc_rsp_valid, spurious_tag});
        end
        tick();
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_priority();
        do_reset();
        drive(2'd1, 32'h100, 2'd1, 32'h200, 64'h0, 4'd3, 4'd0);
        checks++;
        if ({dc_gnt, ic_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL prio_gnt got=%b exp=10", {dc_gnt, ic_gnt});
        end
        checks++;
        if (proc2mem_addr !== 32'h200 || proc2mem_command !== 2'd1) begin
            failures++;
            $display("FAIL prio_port got=%h/%0d exp=200/1", proc2mem_addr, proc2mem_command);
        end
        checks++;
        if (dc_acc_tag !== 4'd3 || ic_acc_tag !== 4'd0) begin
            failures++;
            $display("FAIL prio_acc got=%0d/%0d exp=3/0", dc_acc_tag, ic_acc_tag);
        end
        sb.push_back('{tag: 4'd3, own_d: 1'b1});
        tick();
        drive(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 4'd3);
        checks++;
        if (rsp_data !== 64'hCAFE_0000_0000_0003 || rsp_tag !== 4'd3) begin
            failures++;
            $display("FAIL prio_passthru got=%h/%0d exp=cafe000000000003/3", rsp_data, rsp_tag);
        end
        test_return("prio_ret3", 4'd3);
        // I-side STORE is illegal and must not be presented
        drive(2'd2, 32'h180, 2'd0, 32'h0, 64'h0, 4'd6, 4'd0);
        checks++;
        if (ic_gnt !== 1'b0 || proc2mem_command !== 2'd0 || ic_acc_tag !== 4'd0) begin
            failures++;
            $display("FAIL ic_store_ignored got=%b/%0d/%0d exp=0/0/0", ic_gnt, proc2mem_command, ic_acc_tag);
        end
        tick();
    endtask

    task automatic test_store_lock();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2'd1, 32'h300, 2'd2, 32'h40, 64'hDEADBEEF, (c == 2) ? 4'd5 : 4'd0, 4'd0);
            checks++;
            if (proc2mem_command !== 2'd2 || dc_gnt !== 1'b1 || proc2mem_addr !== 32'h40 ||
                proc2mem_data !== 64'hDEADBEEF) begin
                failures++;
                $display("FAIL store_c%0d got=cmd%0d gnt%0b a=%h d=%h exp=cmd2 gnt1 a=40 d=deadbeef",
                         c, proc2mem_command, dc_gnt, proc2mem_addr, proc2mem_data);
            end
            checks++;
            if (dc_acc_tag !== ((c == 2) ? 4'd5 : 4'd0)) begin
                failures++;
                $display("FAIL store_acc_c%0d got=%0d exp=%0d", c, dc_acc_tag, (c == 2) ? 5 : 0);
            end
            tick();
        end
        test_return("store_ret5", 4'd5);
        checks++;
        if (spurious_tag !== 1'b1) begin
            failures++;
            $display("FAIL store_spurious got=%0b exp=1", spurious_tag);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(2'd1, 32'h500, 2'd1, 32'h600 + 32'(c * 8), 64'h0, 4'(c + 1), 4'd0);
            checks++;
            if ({ic_gnt, dc_gnt} !== ((c == 4) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_c%0d got=%b exp=%b", c, {ic_gnt, dc_gnt}, (c == 4) ? 2'b10 : 2'b01);
            end
            if (c == 4) begin
                checks++;
                if (ic_acc_tag !== 4'd5 || proc2mem_addr !== 32'h500) begin
                    failures++;
                    $display("FAIL starve_win got=%0d/%h exp=5/500", ic_acc_tag, proc2mem_addr);
                end
            end
            sb.push_back('{tag: 4'(c + 1), own_d: (c != 4)});
            tick();
        end
        test_return("starve_ret5", 4'd5);
    endtask

    task automatic test_lock_hold();
        do_reset();
        drive(2'd1, 32'h700, 2'd0, 32'h0, 64'h0, 4'd0, 4'd0);
        tick();
        drive(2'd1, 32'h700, 2'd1, 32'h800, 64'h0, 4'd0, 4'd0);
        checks++;
        if ({ic_gnt, dc_gnt} !== 2'b10 || proc2mem_addr !== 32'h700) begin
            failures++;
            $display("FAIL lock_hold got=%b/%h exp=10/700", {ic_gnt, dc_gnt}, proc2mem_addr);
        end
        tick();
        drive(2'd1, 32'h700, 2'd1, 32'h800, 64'h0, 4'd7, 4'd0);
        checks++;
        if (ic_acc_tag !== 4'd7 || dc_acc_tag !== 4'd0) begin
            failures++;
            $display("FAIL lock_accept got=%0d/%0d exp=7/0", ic_acc_tag, dc_acc_tag);
        end
        sb.push_back('{tag: 4'd7, own_d: 1'b0});
        tick();
        drive(2'd0, 32'h0, 2'd1, 32'h800, 64'h0, 4'd8, 4'd0);
        checks++;
        if (dc_gnt !== 1'b1 || dc_acc_tag !== 4'd8) begin
            failures++;
            $display("FAIL lock_release got=%0b/%0d exp=1/8", dc_gnt, dc_acc_tag);
        end
        sb.push_back('{tag: 4'd8, own_d: 1'b1});
        tick();
        test_return("lock_ret7", 4'd7);
        test_return("lock_ret8", 4'd8);
    endtask

    task automatic test_lock_drop();
        do_reset();
        drive(2'd1, 32'hA00, 2'd0, 32'h0, 64'h0, 4'd0, 4'd0);
        tick();
        drive(2'd0, 32'h0, 2'd1, 32'hB00, 64'h0, 4'd9, 4'd0);
        checks++;
        if (dc_gnt !== 1'b1 || proc2mem_addr !== 32'hB00 || dc_acc_tag !== 4'd9) begin
            failures++;
            $display("FAIL drop_regrant got=%0b/%h/%0d exp=1/b00/9", dc_gnt, proc2mem_addr, dc_acc_tag);
        end
        tick();
        drive(2'd1, 32'hA00, 2'd1, 32'hB08, 64'h0, 4'd0, 4'd0);
        checks++;
        if ({ic_gnt, dc_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL drop_unlocked got=%b exp=01", {ic_gnt, dc_gnt});
        end
        tick();
    endtask

    task automatic test_same_tag();
        bit found, own_d;
        do_reset();
        drive(2'd0, 32'h0, 2'd1, 32'h900, 64'h0, 4'd2, 4'd0);
        sb.push_back('{tag: 4'd2, own_d: 1'b1});
        tick();
        sb_pop(4'd2, found, own_d);
        drive(2'd1, 32'hA00, 2'd0, 32'h0, 64'h0, 4'd2, 4'd2);
        checks++;
        if (dc_rsp_valid !== (found && own_d) || ic_rsp_valid !== (found && !own_d)) begin
            failures++;
            $display("FAIL same_tag_ret got=%0b%0b exp=%0b%0b", dc_rsp_valid, ic_rsp_valid,
                     found && own_d, found && !own_d);
        end
        checks++;
        if (ic_acc_tag !== 4'd2) begin
            failures++;
            $display("FAIL same_tag_acc got=%0d exp=2", ic_acc_tag);
        end
        sb.push_back('{tag: 4'd2, own_d: 1'b0});
        tick();
        test_return("same_tag_ret2", 4'd2);
        checks++;
        if (spurious_tag !== 1'b0) begin
            failures++;
            $display("FAIL same_tag_spurious got=%0b exp=0", spurious_tag);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'd0, 32'h0, 2'd1, 32'h10, 64'h0, 4'd1, 4'd0);
        sb.push_back('{tag: 4'd1, own_d: 1'b1});
        tick();
        drive(2'd1, 32'h20, 2'd0, 32'h0, 64'h0, 4'd4, 4'd0);
        sb.push_back('{tag: 4'd4, own_d: 1'b0});
        tick();
        drive(2'd1, 32'h30, 2'd0, 32'h0, 64'h0, 4'd0, 4'd0);
        tick();
        reset = 1'b0;
        drive(2'd1, 32'h30, 2'd2, 32'h50, 64'h1, 4'd5, 4'd1);
        checks++;
        if ({ic_gnt, dc_gnt, proc2mem_command, ic_acc_tag, dc_acc_tag, ic_rsp_valid, dc_rsp_valid} !== 14'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b exp=0",
                     {ic_gnt, dc_gnt, proc2mem_command, ic_acc_tag, dc_acc_tag, ic_rsp_valid, dc_rsp_valid});
        end
        tick();
        reset = 1'b1;
        sb.delete();
        test_return("midreset_ret4", 4'd4);
        checks++;
        if (spurious_tag !== 1'b1) begin
            failures++;
            $display("FAIL midreset_spurious got=%0b exp=1", spurious_tag);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(2'd0, 32'h0, 2'd0, 32'h0, 64'h0, 4'd0, 4'd0);
        test_reset();
        test_priority();
        test_store_lock();
        test_starvation();
        test_lock_hold();
        test_lock_drop();
        test_same_tag();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
